// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// the bubble instruction and the default reset PC.
package pipe_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetch_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   // Word-align a target address by clearing the byte offset.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'd3;
   endfunction

endpackage

// File: rtl/if_pc_reg.sv
// Program counter register: reset, redirect load (word-aligned), and +4
// advance. The increment wraps naturally at 2^32.
module if_pc_reg
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [31:0] i_load_pc,
   input  logic        i_inc,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_plus4
);

   logic [31:0] r_pc;
   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = r_pc + 32'd4;

   // Reset wins, then a redirect load, then the sequential advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc <= RESET_PC;
      end else if (i_load) begin
         r_pc <= word_align(i_load_pc);
      end else if (i_inc) begin
         r_pc <= w_pc_plus4;
      end
   end

   assign o_pc       = r_pc;
   assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. Keeps one request
// outstanding to instruction memory, buffers the returned word and hands
// it to IF/ID under hazard-unit control. An EX redirect flushes IF/ID with
// a bubble in the same cycle and steers the PC to the branch target.
//
// state | meaning
// ------+---------------------------------------------------------------
// REQ   | issue a fetch for pc_q
// WAIT  | request outstanding, waiting for imem_rvalid
// HOLD  | instruction buffered and presented; advance when PC_Write=1
// DROP  | stale request outstanding after a redirect; discard its data
module if_fetch_unit
   import pipe_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        PC_Write,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_PC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] PC_IF,
   output logic [31:0] inst_IF,
   output logic        IF_ID_Write
);

   fetch_state_t r_state;
   logic [31:0]  r_inst_buf;
   logic [31:0]  r_pc_buf;

   logic [31:0]  w_pc_q;
   logic [31:0]  w_pc_plus4;
   logic         w_hold;
   logic         w_fire;
   logic         w_flush;

   assign w_hold  = (r_state == HOLD);
   // A redirect outranks the hand-off: the branch is older than the
   // instruction sitting in the buffer.
   assign w_fire  = w_hold && PC_Write && !redirect_valid;
   assign w_flush = redirect_valid && !rst;

   if_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (redirect_valid),
      .i_load_pc  (redirect_PC),
      .i_inc      (w_fire),
      .o_pc       (w_pc_q),
      .o_pc_plus4 (w_pc_plus4)
   );

   // Request side: REQ fetches pc_q; HOLD chains the next fetch into the
   // hand-off cycle so a 1-cycle memory sustains one instruction per two
   // cycles. Redirect and reset suppress any request.
   assign imem_req  = !rst && !redirect_valid &&
                      ((r_state == REQ) || (w_hold && PC_Write));
   assign imem_addr = w_hold ? w_pc_plus4 : w_pc_q;

   // IF/ID side: the buffered pair is presented from registers; a flush
   // (or reset) overrides it with a bubble at PC 0.
   assign IF_ID_Write = !rst && (redirect_valid || (w_hold && PC_Write));
   assign PC_IF       = (rst || w_flush) ? 32'd0    : r_pc_buf;
   assign inst_IF     = (rst || w_flush) ? NOP_INST : r_inst_buf;

   // Fetch FSM and instruction buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= REQ;
         r_inst_buf <= NOP_INST;
         r_pc_buf   <= 32'd0;
      end else if (redirect_valid) begin
         // Whatever is buffered belongs to the wrong path.
         r_inst_buf <= NOP_INST;
         r_pc_buf   <= 32'd0;
         case (r_state)
            // A request still in flight must be drained before refetching;
            // if its response lands this very cycle it is simply dropped.
            WAIT, DROP: r_state <= imem_rvalid ? REQ : DROP;
            default:    r_state <= REQ;
         endcase
      end else begin
         case (r_state)
            REQ: begin
               r_state <= WAIT;
            end
            WAIT: begin
               if (imem_rvalid) begin
                  r_inst_buf <= imem_rdata;
                  r_pc_buf   <= w_pc_q;
                  r_state    <= HOLD;
               end
            end
            HOLD: begin
               if (PC_Write) begin
                  r_state <= WAIT;
               end
            end
            DROP: begin
               if (imem_rvalid) begin
                  r_state <= REQ;
               end
            end
            default: begin
               r_state <= REQ;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a latency-programmable memory model answers
// requests; stimulus pushes expected (cycle, address) requests and
// (cycle, PC, instruction) IF/ID writes into queues, and a negedge monitor
// pops and compares whenever the DUT asserts imem_req or IF_ID_Write.
module tb_if_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        PC_Write;
   logic        redirect_valid;
   logic [31:0] redirect_PC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] PC_IF;
   logic [31:0] inst_IF;
   logic        IF_ID_Write;

   if_fetch_unit dut (
      .clk            (clk),
      .rst            (rst),
      .PC_Write       (PC_Write),
      .redirect_valid (redirect_valid),
      .redirect_PC    (redirect_PC),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .PC_IF          (PC_IF),
      .inst_IF        (inst_IF),
      .IF_ID_Write    (IF_ID_Write)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   int base   = 0;
   int mem_lat = 1;

   typedef struct {
      int          c;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   typedef struct {
      int          due;
      logic [31:0] a;
   } pend_t;

   exp_t  req_q[$];
   exp_t  wr_q[$];
   pend_t pend_q[$];
   exp_t  e_req;
   exp_t  e_wr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'd0) ? 32'h00A0_0093 : (a ^ 32'h1234_0013);
   endfunction

   function automatic void exp_req(input int k, input logic [31:0] a);
      req_q.push_back('{c: base + k, a: a, d: 32'd0});
   endfunction

   function automatic void exp_wr(input int k, input logic [31:0] pc, input logic [31:0] inst);
      wr_q.push_back('{c: base + k, a: pc, d: inst});
   endfunction

   // Memory model: responds mem_lat cycles after the request cycle.
   initial begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      forever begin
         @(posedge clk);
         #1;
         imem_rvalid = 1'b0;
         imem_rdata  = 32'hDEAD_BEEF;
         for (int i = 0; i < pend_q.size(); i++) begin
            if (pend_q[i].due == cyc) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(pend_q[i].a);
               pend_q.delete(i);
               break;
            end
         end
      end
   end

   // Monitor: every request and every IF/ID write must match the head of
   // its expectation queue, including the cycle it happens in.
   always @(negedge clk) begin
      if (imem_req !== 1'b0) begin
         pend_q.push_back('{due: cyc + mem_lat, a: imem_addr});
         checks++;
         if (req_q.size() == 0) begin
            errors++;
            $display("FAIL req_unexpected: cycle %0d addr %h, required no request", cyc - base, imem_addr);
         end else begin
            e_req = req_q.pop_front();
            if (e_req.c != cyc || e_req.a !== imem_addr) begin
               errors++;
               $display("FAIL req: got cycle %0d addr %h, required cycle %0d addr %h",
                        cyc - base, imem_addr, e_req.c - base, e_req.a);
            end
         end
      end
      if (IF_ID_Write !== 1'b0) begin
         checks++;
         if (wr_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: cycle %0d pc %h inst %h, required no write",
                     cyc - base, PC_IF, inst_IF);
         end else begin
            e_wr = wr_q.pop_front();
            if (e_wr.c != cyc || e_wr.a !== PC_IF || e_wr.d !== inst_IF) begin
               errors++;
               $display("FAIL wr: got cycle %0d pc %h inst %h, required cycle %0d pc %h inst %h",
                        cyc - base, PC_IF, inst_IF, e_wr.c - base, e_wr.a, e_wr.d);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic go(input int k);
      while (cyc - base < k) step();
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   initial begin
      rst            = 1'b1;
      PC_Write       = 1'b1;
      redirect_valid = 1'b0;
      redirect_PC    = 32'd0;
      repeat (3) step();
      @(negedge clk);
      chk("rst_ifid_write", {31'd0, IF_ID_Write}, 32'd0);
      chk("rst_imem_req",   {31'd0, imem_req},    32'd0);
      chk("rst_pc_if",      PC_IF,                32'd0);
      chk("rst_inst_if",    inst_IF,              NOP);
      step();

      // Cycle 0: first cycle out of reset.
      rst  = 1'b0;
      base = cyc;

      exp_req(0,  32'h0000_0000);
      exp_wr (2,  32'h0000_0000, 32'h00A0_0093);
      exp_req(2,  32'h0000_0004);
      exp_wr (4,  32'h0000_0004, mem_word(32'h4));
      exp_req(4,  32'h0000_0008);
      exp_wr (9,  32'h0000_0008, mem_word(32'h8));
      exp_req(9,  32'h0000_000C);
      exp_wr (11, 32'h0000_0000, NOP);
      exp_req(12, 32'h0000_0100);
      exp_wr (14, 32'h0000_0100, mem_word(32'h100));
      exp_req(14, 32'h0000_0104);
      exp_wr (15, 32'h0000_0000, NOP);
      exp_req(18, 32'h0000_0200);
      exp_wr (20, 32'h0000_0200, mem_word(32'h200));
      exp_req(20, 32'h0000_0204);
      exp_wr (21, 32'h0000_0000, NOP);
      exp_req(22, 32'h0000_0300);
      exp_wr (23, 32'h0000_0000, NOP);
      exp_wr (24, 32'h0000_0000, NOP);
      exp_req(26, 32'h0000_0500);
      exp_wr (28, 32'h0000_0500, mem_word(32'h500));
      exp_req(28, 32'h0000_0504);
      exp_wr (29, 32'h0000_0000, NOP);
      exp_req(30, 32'hFFFF_FFFC);
      exp_wr (32, 32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC));
      exp_req(32, 32'h0000_0000);
      exp_req(35, 32'h0000_0000);
      exp_wr (37, 32'h0000_0000, 32'h00A0_0093);
      exp_req(37, 32'h0000_0004);

      @(negedge clk);
      chk("post_rst_pc_if",   PC_IF,   32'd0);
      chk("post_rst_inst_if", inst_IF, NOP);

      // Stall three cycles in HOLD with PC 8 buffered.
      go(6);
      PC_Write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_pc_if",   PC_IF,                32'h0000_0008);
         chk("stall_inst_if", inst_IF,              mem_word(32'h8));
         chk("stall_write",   {31'd0, IF_ID_Write}, 32'd0);
         chk("stall_req",     {31'd0, imem_req},    32'd0);
         step();
      end
      PC_Write = 1'b1;

      // Redirect while stalled in HOLD.
      go(11);
      PC_Write       = 1'b0;
      redirect_valid = 1'b1;
      redirect_PC    = 32'h0000_0100;
      go(12);
      redirect_valid = 1'b0;
      PC_Write       = 1'b1;

      // 3-cycle memory, misaligned redirect one cycle after the request.
      go(14);
      mem_lat = 3;
      go(15);
      redirect_valid = 1'b1;
      redirect_PC    = 32'h0000_0203;
      go(16);
      redirect_valid = 1'b0;
      go(18);
      mem_lat = 1;

      // Redirect coinciding with rvalid in WAIT.
      go(21);
      redirect_valid = 1'b1;
      redirect_PC    = 32'h0000_0300;
      go(22);
      redirect_valid = 1'b0;
      mem_lat        = 3;

      // Two redirects back to back: WAIT->DROP, then DROP; last wins.
      go(23);
      redirect_valid = 1'b1;
      redirect_PC    = 32'h0000_0400;
      go(24);
      redirect_PC    = 32'h0000_0500;
      go(25);
      redirect_valid = 1'b0;
      go(26);
      mem_lat = 1;

      // Fetch at the top of the address space and wrap.
      go(29);
      redirect_valid = 1'b1;
      redirect_PC    = 32'hFFFF_FFFC;
      go(30);
      redirect_valid = 1'b0;
      go(32);
      mem_lat = 3;

      // Reset mid-WAIT; the late response lands while in REQ.
      go(33);
      rst = 1'b1;
      go(35);
      rst     = 1'b0;
      mem_lat = 1;
      go(39);
      PC_Write = 1'b0;
      go(42);

      while (req_q.size() > 0) begin
         e_req = req_q.pop_front();
         checks++;
         errors++;
         $display("FAIL req_missing: got none, required cycle %0d addr %h", e_req.c - base, e_req.a);
      end
      while (wr_q.size() > 0) begin
         e_wr = wr_q.pop_front();
         checks++;
         errors++;
         $display("FAIL wr_missing: got none, required cycle %0d pc %h inst %h",
                  e_wr.c - base, e_wr.a, e_wr.d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register.
- Owns the PC and talks to an instruction memory through a one-outstanding request/response interface.
- Buffers the returned instruction and presents PC_IF/inst_IF with an IF_ID_Write strobe.
- Honours hazard-unit stalls and EX-stage redirects (branch/jump); a redirect flushes IF/ID by writing a NOP.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) written on flush.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- PC_Write  in  1  hazard unit: 1 = IF may hand its instruction to IF/ID and advance; 0 = stall.
- redirect_valid  in  1  EX stage: taken branch/jump this cycle.
- redirect_PC  in  32  redirect target.
- imem_req  out  1  one-cycle request pulse; memory always accepts.
- imem_addr  out  32  request address; valid when imem_req=1.
- imem_rvalid  in  1  response valid, 1..N cycles after request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- PC_IF  out  32  PC of the presented instruction; goes to IF/ID input PC.
- inst_IF  out  32  presented instruction; goes to IF/ID input inst.
- IF_ID_Write  out  1  write enable for IF/ID.

Behaviour:
- State machine: REQ, WAIT, HOLD, DROP.
- Registers: pc_q, inst_buf, pc_buf.
- Reset (rst=1 at posedge): state=REQ, pc_q=RESET_PC, inst_buf=NOP_INST, pc_buf=0.
  - During and directly after reset: imem_req=0 while rst=1, IF_ID_Write=0, PC_IF=0, inst_IF=NOP_INST.
  - Reset mid-WAIT or mid-DROP abandons the request. Any imem_rvalid while in REQ or HOLD is ignored.
- REQ:
  - imem_req=1, imem_addr=pc_q; next state WAIT.
  - IF_ID_Write=0.
- WAIT:
  - On imem_rvalid: inst_buf<=imem_rdata, pc_buf<=pc_q; next state HOLD.
  - Otherwise stay in WAIT.
  - IF_ID_Write=0.
- HOLD:
  - PC_IF=pc_buf, inst_IF=inst_buf, IF_ID_Write=PC_Write.
  - If PC_Write=1: pc_q<=pc_q+4, and the next request issues in the same cycle (imem_req=1, imem_addr=pc_q+4); next state WAIT.
  - If PC_Write=0: hold all outputs stable and stay in HOLD.
- Throughput: with 1-cycle memory and no stalls, one instruction per 2 cycles.
- First IF_ID_Write after reset: REQ at cycle 0, rvalid at cycle 1, HOLD at cycle 2, so IF_ID_Write is first asserted in cycle 2.
- Redirect (redirect_valid=1) has the highest priority and overrides PC_Write=0, because the branch is older than the stalled instruction.
  - Target: pc_q<=redirect_PC with bits[1:0] forced to 0.
  - Flush in the same cycle: IF_ID_Write=1, inst_IF=NOP_INST, PC_IF=0. This applies in every state.
  - From REQ or HOLD: next state REQ; the buffered instruction is discarded; no imem_req that cycle.
  - From WAIT with imem_rvalid=0: next state DROP.
  - From WAIT with imem_rvalid=1 the same cycle: the response is discarded; next state REQ.
  - From DROP: update pc_q and stay in DROP.
- DROP:
  - Wait for imem_rvalid, discard the data, then go to REQ.
  - IF_ID_Write=0 unless a redirect occurs.
- Arithmetic: pc_q+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 0); no overflow flag.
- Outputs PC_IF and inst_IF come from registers, except for the combinational flush override. IF_ID_Write is combinational from state, PC_Write and redirect_valid.

Decomposition:
- Shared package pipe_pkg: fetch state enum (REQ, WAIT, HOLD, DROP), NOP_INST constant, default RESET_PC.
- One sub-module, if_pc_reg: pc_q with reset, redirect load, +4 increment and wrap.
- The FSM and buffer stay in if_fetch_unit.

Test Plan:
- Reset, then 1-cycle memory returning 0x00A00093 at addr 0, PC_Write=1 -> imem_req at cycle 0 with addr 0; IF_ID_Write=1 in cycle 2 with PC_IF=0, inst_IF=0x00A00093; next imem_addr=4 issued in the same cycle.
- PC_Write=0 for 3 cycles while in HOLD -> IF_ID_Write=PC_Write=0 throughout; PC_IF/inst_IF stable; no imem_req; PC_Write=1 -> fire and imem_addr=pc+4.
- redirect_valid with redirect_PC=0x100 while in HOLD with PC_Write=0 -> same cycle IF_ID_Write=1, inst_IF=0x00000013, PC_IF=0; next cycle imem_req with addr 0x100.
- 3-cycle memory, redirect to 0x203 one cycle after the request -> stale rvalid discarded (no IF_ID_Write); then imem_req with addr 0x200.
- Redirect in the same cycle as rvalid in WAIT -> data discarded; REQ to the target next cycle. Second redirect while in DROP -> last target wins.
- pc_q=0xFFFF_FFFC fetched and advanced -> next imem_addr=0x0000_0000. rst asserted mid-WAIT -> next request at RESET_PC; the late rvalid is ignored.
